// File: rtl/pc_gen_unit_if.sv
// Fetch-side handshake between the IF stage controller and pc_gen_unit.
// Redirect sources, stall and the generated PC/status all travel on this bundle.
interface pc_gen_if #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_SRC = 4
);
  logic                      stall;
  logic [NUM_SRC-1:0]        redirect_valid;
  logic [NUM_SRC*XLEN-1:0]   redirect_target;
  logic [XLEN-1:0]           pc;
  logic [XLEN-1:0]           pc_plus_4;
  logic                      pc_valid;
  logic                      redirect_taken;
  logic                      misalign_err;
  logic [XLEN-1:0]           misalign_addr;

  // Requester side: drives stall and redirect requests, observes the PC.
  modport master (
    output stall, redirect_valid, redirect_target,
    input  pc, pc_plus_4, pc_valid, redirect_taken, misalign_err, misalign_addr
  );

  // PC generator side.
  modport slave (
    input  stall, redirect_valid, redirect_target,
    output pc, pc_plus_4, pc_valid, redirect_taken, misalign_err, misalign_addr
  );
endinterface

// File: rtl/pc_gen_unit.sv
// Program-counter generator for the IF stage.
// Selects next PC from sequential +4 or the highest-priority redirect source
// (index 0 wins), aligns redirect targets and flags misaligned ones, and pulses
// redirect_taken for one cycle so IF can flush.
// Optional build macro PC_REDIRECT_HOLD_EN: redirects seen under stall are
// parked in a single pending slot and applied when the stall releases,
// instead of overriding the stall.
module pc_gen_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter int unsigned     NUM_SRC      = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     IALIGN       = 32
) (
  input logic     clk,
  input logic     rst_n,
  pc_gen_if.slave bus
);

  localparam logic [XLEN-1:0] ALIGN_MASK = (IALIGN == 16) ? XLEN'(1) : XLEN'(3);
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

  // Registered state
  logic [XLEN-1:0] pc_q;
  logic            pc_valid_q;
  logic            taken_q;
  logic            mis_q;
  logic [XLEN-1:0] mis_addr_q;

  // Next-state values
  logic [XLEN-1:0] pc_d;
  logic            taken_d;
  logic            mis_d;
  logic [XLEN-1:0] mis_addr_d;

  // Winning redirect source for this cycle
  logic            sel_found;
  logic [XLEN-1:0] sel_target;
  logic [XLEN-1:0] sel_aligned;
  logic            sel_misaligned;

`ifdef PC_REDIRECT_HOLD_EN
  localparam int unsigned IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [IDX_W-1:0] sel_idx;
  logic             new_wins;

  logic             pend_valid_q;
  logic [XLEN-1:0]  pend_target_q;
  logic [IDX_W-1:0] pend_idx_q;
  logic             pend_valid_d;
  logic [XLEN-1:0]  pend_target_d;
  logic [IDX_W-1:0] pend_idx_d;
`endif

  // Priority pick: lowest set index wins; other targets are never examined.
  always_comb begin
    sel_found  = 1'b0;
    sel_target = '0;
`ifdef PC_REDIRECT_HOLD_EN
    sel_idx    = '0;
`endif
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (bus.redirect_valid[i] && !sel_found) begin
        sel_found  = 1'b1;
        sel_target = bus.redirect_target[i*XLEN +: XLEN];
`ifdef PC_REDIRECT_HOLD_EN
        sel_idx    = IDX_W'(i);
`endif
      end
    end
  end

  assign sel_misaligned = |(sel_target & ALIGN_MASK);
  assign sel_aligned    = sel_target & ~ALIGN_MASK;

`ifdef PC_REDIRECT_HOLD_EN
  // A fresh request displaces the pending one only at equal or higher priority.
  assign new_wins = sel_found && (!pend_valid_q || (sel_idx <= pend_idx_q));
`endif

  // Next-PC selection and status pulses; nothing moves until pc_valid is up.
  always_comb begin
    pc_d       = pc_q;
    taken_d    = 1'b0;
    mis_d      = 1'b0;
    mis_addr_d = mis_addr_q;
`ifdef PC_REDIRECT_HOLD_EN
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    pend_idx_d    = pend_idx_q;
`endif
    if (pc_valid_q) begin
`ifdef PC_REDIRECT_HOLD_EN
      // Alignment is judged when a request is accepted (latched or loaded),
      // so a pending target is already aligned when it finally reaches pc.
      if (bus.stall) begin
        if (new_wins) begin
          pend_valid_d  = 1'b1;
          pend_target_d = sel_aligned;
          pend_idx_d    = sel_idx;
          if (sel_misaligned) begin
            mis_d      = 1'b1;
            mis_addr_d = sel_target;
          end
        end
      end else if (new_wins) begin
        pc_d         = sel_aligned;
        taken_d      = 1'b1;
        pend_valid_d = 1'b0;
        if (sel_misaligned) begin
          mis_d      = 1'b1;
          mis_addr_d = sel_target;
        end
      end else if (pend_valid_q) begin
        pc_d         = pend_target_q;
        taken_d      = 1'b1;
        pend_valid_d = 1'b0;
      end else begin
        pc_d = pc_q + PC_STEP;
      end
`else
      if (sel_found) begin
        pc_d    = sel_aligned;
        taken_d = 1'b1;
        if (sel_misaligned) begin
          mis_d      = 1'b1;
          mis_addr_d = sel_target;
        end
      end else if (!bus.stall) begin
        pc_d = pc_q + PC_STEP;
      end
`endif
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_VECTOR;
      pc_valid_q <= 1'b0;
      taken_q    <= 1'b0;
      mis_q      <= 1'b0;
      mis_addr_q <= '0;
    end else begin
      pc_q       <= pc_d;
      pc_valid_q <= 1'b1;
      taken_q    <= taken_d;
      mis_q      <= mis_d;
      mis_addr_q <= mis_addr_d;
    end
  end

`ifdef PC_REDIRECT_HOLD_EN
  // Pending redirect slot, cleared on reset and whenever it is consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
      pend_idx_q    <= '0;
    end else begin
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      pend_idx_q    <= pend_idx_d;
    end
  end
`endif

  assign bus.pc             = pc_q;
  assign bus.pc_plus_4      = pc_q + PC_STEP;
  assign bus.pc_valid       = pc_valid_q;
  assign bus.redirect_taken = taken_q;
  assign bus.misalign_err   = mis_q;
  assign bus.misalign_addr  = mis_addr_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Directed self-checking bench for pc_gen_unit (default parameters).
module tb_pc_gen_unit;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  pc_gen_if #(.XLEN(32), .NUM_SRC(4)) bus ();

  pc_gen_unit #(
    .XLEN(32),
    .NUM_SRC(4),
    .RESET_VECTOR(32'h0000_0000),
    .IALIGN(32)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_tgt(input int idx, input logic [31:0] v);
    bus.redirect_target[idx*32 +: 32] = v;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.stall = 1'b0;
    bus.redirect_valid = '0;
    bus.redirect_target = '0;

    // Reset held for three edges
    repeat (3) tick();
    chk("rst_pc",       bus.pc, 32'h0);
    chk("rst_valid",    32'(bus.pc_valid), 32'd0);
    chk("rst_taken",    32'(bus.redirect_taken), 32'd0);
    chk("rst_mis",      32'(bus.misalign_err), 32'd0);
    chk("rst_mis_addr", bus.misalign_addr, 32'h0);

    // Release: pc_valid rises, pc still at reset vector, then +4 stepping
    rst_n = 1'b1;
    tick();
    chk("rel_pc",    bus.pc, 32'h0);
    chk("rel_valid", 32'(bus.pc_valid), 32'd1);
    tick();
    chk("seq_pc4", bus.pc, 32'h4);
    tick();
    chk("seq_pc8",   bus.pc, 32'h8);
    chk("seq_plus4", bus.pc_plus_4, 32'hC);

    // Two simultaneous redirects: index 1 beats index 2
    bus.redirect_valid = 4'b0110;
    set_tgt(1, 32'h100);
    set_tgt(2, 32'h200);
    tick();
    chk("prio_pc",    bus.pc, 32'h100);
    chk("prio_taken", 32'(bus.redirect_taken), 32'd1);
    bus.redirect_valid = '0;
    tick();
    chk("prio_next",  bus.pc, 32'h104);
    chk("prio_pulse", 32'(bus.redirect_taken), 32'd0);

    // Move to 0x40, then stall three cycles
    bus.redirect_valid = 4'b0001;
    set_tgt(0, 32'h40);
    tick();
    chk("to40", bus.pc, 32'h40);
    bus.redirect_valid = '0;
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc",    bus.pc, 32'h40);
      chk("stall_plus4", bus.pc_plus_4, 32'h44);
      chk("stall_taken", 32'(bus.redirect_taken), 32'd0);
    end
    bus.stall = 1'b0;
    tick();
    chk("stall_rel", bus.pc, 32'h44);

    // Misaligned target on source 3
    bus.redirect_valid = 4'b1000;
    set_tgt(3, 32'h202);
    tick();
    chk("mis_pc",   bus.pc, 32'h200);
    chk("mis_err",  32'(bus.misalign_err), 32'd1);
    chk("mis_addr", bus.misalign_addr, 32'h202);
    bus.redirect_valid = '0;
    tick();
    chk("mis_next",      bus.pc, 32'h204);
    chk("mis_err_pulse", 32'(bus.misalign_err), 32'd0);
    chk("mis_addr_hold", bus.misalign_addr, 32'h202);

    // Lower-priority misaligned target must be ignored
    bus.redirect_valid = 4'b0011;
    set_tgt(0, 32'h500);
    set_tgt(1, 32'h603);
    tick();
    chk("lowprio_pc",   bus.pc, 32'h500);
    chk("lowprio_err",  32'(bus.misalign_err), 32'd0);
    chk("lowprio_addr", bus.misalign_addr, 32'h202);

    // Wrap at top of address space
    bus.redirect_valid = 4'b0001;
    set_tgt(0, 32'hFFFF_FFFC);
    tick();
    chk("wrap_top",   bus.pc, 32'hFFFF_FFFC);
    chk("wrap_plus4", bus.pc_plus_4, 32'h0);
    bus.redirect_valid = '0;
    tick();
    chk("wrap_pc", bus.pc, 32'h0);

    // Redirect under stall
    bus.stall = 1'b1;
    bus.redirect_valid = 4'b0100;
    set_tgt(2, 32'h300);
    tick();
`ifdef PC_REDIRECT_HOLD_EN
    chk("sr_pc",    bus.pc, 32'h0);
    chk("sr_taken", 32'(bus.redirect_taken), 32'd0);
    bus.redirect_valid = '0;
    tick();
    chk("sr_hold", bus.pc, 32'h0);
    bus.stall = 1'b0;
    tick();
    chk("sr_load",       bus.pc, 32'h300);
    chk("sr_load_taken", 32'(bus.redirect_taken), 32'd1);
`else
    chk("sr_pc",    bus.pc, 32'h300);
    chk("sr_taken", 32'(bus.redirect_taken), 32'd1);
    bus.redirect_valid = '0;
    tick();
    chk("sr_hold",       bus.pc, 32'h300);
    chk("sr_hold_taken", 32'(bus.redirect_taken), 32'd0);
    bus.stall = 1'b0;
    tick();
    chk("sr_rel", bus.pc, 32'h304);
`endif

    // Reset in the middle of a stall with a redirect pending
    bus.stall = 1'b1;
    bus.redirect_valid = 4'b0010;
    set_tgt(1, 32'h800);
    rst_n = 1'b0;
    tick();
    chk("mrst_pc",    bus.pc, 32'h0);
    chk("mrst_valid", 32'(bus.pc_valid), 32'd0);
    chk("mrst_taken", 32'(bus.redirect_taken), 32'd0);
    bus.redirect_valid = '0;
    bus.stall = 1'b0;
    rst_n = 1'b1;
    tick();
    tick();
    chk("mrst_seq", bus.pc, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
